// File: rtl/perf_csr_file_pkg.sv
// Shared definitions for the performance-counter CSR read front end:
// CSR address map, read-select encoding and the address decoder.
package perf_csr_file_pkg;

    // User-level counter CSR addresses (RISC-V numbering)
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_HPM3     = 12'hC03;
    localparam logic [11:0] CSR_HPM4     = 12'hC04;
    localparam logic [11:0] CSR_HPM5     = 12'hC05;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;
    localparam logic [11:0] CSR_HPM3H    = 12'hC83;
    localparam logic [11:0] CSR_HPM4H    = 12'hC84;
    localparam logic [11:0] CSR_HPM5H    = 12'hC85;

    // What a decoded read address selects
    typedef enum logic [3:0] {
        SelIllegal,
        SelCycleLo,
        SelCycleHi,
        SelInstretLo,
        SelInstretHi,
        SelHpm3,
        SelHpm4,
        SelHpm5,
        SelZero
    } csr_sel_e;

    // Map a 12-bit CSR address onto a read source
    function automatic csr_sel_e decode_csr(input logic [11:0] addr);
        csr_sel_e sel;
        case (addr)
            CSR_CYCLE:    sel = SelCycleLo;
            CSR_CYCLEH:   sel = SelCycleHi;
            CSR_INSTRET:  sel = SelInstretLo;
            CSR_INSTRETH: sel = SelInstretHi;
            CSR_HPM3:     sel = SelHpm3;
            CSR_HPM4:     sel = SelHpm4;
            CSR_HPM5:     sel = SelHpm5;
            // 32-bit event counters have no upper half; those reads are legal zeros
            CSR_HPM3H,
            CSR_HPM4H,
            CSR_HPM5H:    sel = SelZero;
            default:      sel = SelIllegal;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/perf_hi_extend.sv
// Extends a free-running low counter word to 64 bits by counting falling
// edges of its MSB, with an optional hi-word snapshot taken on lo reads.
module perf_hi_extend
    import perf_csr_file_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter bit          SNAPSHOT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lo_msb,
    input  logic             lo_read,
    input  logic             hi_read,
    output logic [CNT_W-1:0] hi_rdata
);

    logic             prev_msb_q;
    logic [CNT_W-1:0] hi_q;
    logic             wrap;
    logic [CNT_W-1:0] hi_eff;

    // Low word grows by at most one per cycle, so an MSB 1->0 step is a wrap
    assign wrap   = prev_msb_q & ~lo_msb;
    assign hi_eff = hi_q + CNT_W'(wrap);

    // Track the low-word MSB and bump the high word on each wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_msb_q <= 1'b0;
            hi_q       <= '0;
        end else begin
            prev_msb_q <= lo_msb;
            if (wrap) begin
                hi_q <= hi_q + 1'b1;
            end
        end
    end

    if (SNAPSHOT_EN) begin : g_shadow
        logic [CNT_W-1:0] shadow_q;
        logic             shadow_vld_q;

        // Lo read arms the shadow with the high word it belongs to; hi read consumes it
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_q     <= '0;
                shadow_vld_q <= 1'b0;
            end else if (lo_read) begin
                shadow_q     <= hi_eff;
                shadow_vld_q <= 1'b1;
            end else if (hi_read) begin
                shadow_vld_q <= 1'b0;
            end
        end

        assign hi_rdata = shadow_vld_q ? shadow_q : hi_eff;
    end else begin : g_no_shadow
        assign hi_rdata = hi_eff;
    end

endmodule

// File: rtl/perf_csr_file.sv
// Read-only CSR front end for the performance counters: serves cycle and
// instret as 64-bit values plus three 32-bit event counters, one cycle latency.
module perf_csr_file
    import perf_csr_file_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter bit          SNAPSHOT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cycle_count,
    input  logic [CNT_W-1:0] instruction_count,
    input  logic [CNT_W-1:0] stall_count,
    input  logic [CNT_W-1:0] branch_count,
    input  logic [CNT_W-1:0] branch_mispredicts,
    input  logic             rd_req,
    input  logic [11:0]      rd_addr,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_err
);

    csr_sel_e         sel;
    logic [CNT_W-1:0] cycle_hi_rdata;
    logic [CNT_W-1:0] instret_hi_rdata;
    logic [CNT_W-1:0] resp_data;
    logic             resp_err;

    assign sel = decode_csr(rd_addr);

    perf_hi_extend #(
        .CNT_W       (CNT_W),
        .SNAPSHOT_EN (SNAPSHOT_EN)
    ) u_cycle_hi (
        .clk      (clk),
        .reset    (reset),
        .lo_msb   (cycle_count[CNT_W-1]),
        .lo_read  (rd_req && (sel == SelCycleLo)),
        .hi_read  (rd_req && (sel == SelCycleHi)),
        .hi_rdata (cycle_hi_rdata)
    );

    perf_hi_extend #(
        .CNT_W       (CNT_W),
        .SNAPSHOT_EN (SNAPSHOT_EN)
    ) u_instret_hi (
        .clk      (clk),
        .reset    (reset),
        .lo_msb   (instruction_count[CNT_W-1]),
        .lo_read  (rd_req && (sel == SelInstretLo)),
        .hi_read  (rd_req && (sel == SelInstretHi)),
        .hi_rdata (instret_hi_rdata)
    );

    // Select the response word for the decoded address
    always_comb begin
        resp_data = '0;
        resp_err  = 1'b0;
        case (sel)
            SelCycleLo:   resp_data = cycle_count;
            SelCycleHi:   resp_data = cycle_hi_rdata;
            SelInstretLo: resp_data = instruction_count;
            SelInstretHi: resp_data = instret_hi_rdata;
            SelHpm3:      resp_data = stall_count;
            SelHpm4:      resp_data = branch_count;
            SelHpm5:      resp_data = branch_mispredicts;
            SelZero:      resp_data = '0;
            default:      resp_err  = 1'b1;
        endcase
    end

    // Register the response; data and error hold between requests
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= resp_data;
                rd_err  <= resp_err;
            end
        end
    end

endmodule

// File: tb/tb_perf_csr_file.sv
// Self-checking bench for perf_csr_file: directed scenarios plus randomized
// reads against a 64-bit counter model.
module tb_perf_csr_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cycle_count, instruction_count, stall_count, branch_count, branch_mispredicts;
    logic        rd_req;
    logic [11:0] rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_err;

    always #5 clk = ~clk;

    perf_csr_file #(
        .CNT_W       (32),
        .SNAPSHOT_EN (1'b1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cycle_count        (cycle_count),
        .instruction_count  (instruction_count),
        .stall_count        (stall_count),
        .branch_count       (branch_count),
        .branch_mispredicts (branch_mispredicts),
        .rd_req             (rd_req),
        .rd_addr            (rd_addr),
        .rd_valid           (rd_valid),
        .rd_data            (rd_data),
        .rd_err             (rd_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: true 64-bit counters plus software-visible shadow state
    logic [63:0] cyc64, ins64;
    logic [31:0] stall_v, br_v, mis_v;
    logic        sh_vld_c, sh_vld_i;
    logic [31:0] sh_c, sh_i;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_err;

    logic [11:0] addr_tab [12] = '{12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC03, 12'hC04,
                                   12'hC05, 12'hC83, 12'hC84, 12'hC85, 12'h300, 12'hC01};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Architectural meaning of a CSR read at the current model state
    task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        d = 32'h0;
        e = 1'b0;
        case (a)
            12'hC00: begin d = cyc64[31:0]; sh_c = cyc64[63:32]; sh_vld_c = 1'b1; end
            12'hC80: begin d = sh_vld_c ? sh_c : cyc64[63:32]; sh_vld_c = 1'b0; end
            12'hC02: begin d = ins64[31:0]; sh_i = ins64[63:32]; sh_vld_i = 1'b1; end
            12'hC82: begin d = sh_vld_i ? sh_i : ins64[63:32]; sh_vld_i = 1'b0; end
            12'hC03: d = stall_v;
            12'hC04: d = br_v;
            12'hC05: d = mis_v;
            12'hC83, 12'hC84, 12'hC85: d = 32'h0;
            default: e = 1'b1;
        endcase
    endtask

    // One clock: check the response to the previous cycle, then drive this cycle
    task automatic step(input logic req, input logic [11:0] a);
        logic [31:0] d;
        logic        e;
        @(negedge clk);
        check("rd_valid", 32'(rd_valid), 32'(exp_valid));
        check("rd_data", rd_data, exp_data);
        check("rd_err", 32'(rd_err), 32'(exp_err));
        cycle_count        = cyc64[31:0];
        instruction_count  = ins64[31:0];
        stall_count        = stall_v;
        branch_count       = br_v;
        branch_mispredicts = mis_v;
        rd_req             = req;
        rd_addr            = a;
        if (req) begin
            model_read(a, d, e);
            exp_data = d;
            exp_err  = e;
        end
        exp_valid = req;
    endtask

    initial begin
        logic        req;
        logic [11:0] a;

        reset = 1'b1;
        rd_req = 1'b0;
        rd_addr = 12'h0;
        cyc64 = 64'h0; ins64 = 64'h0;
        stall_v = 32'h0; br_v = 32'h0; mis_v = 32'h0;
        sh_vld_c = 1'b0; sh_vld_i = 1'b0; sh_c = 32'h0; sh_i = 32'h0;
        exp_valid = 1'b0; exp_data = 32'h0; exp_err = 1'b0;
        cycle_count = 32'h0; instruction_count = 32'h0;
        stall_count = 32'h0; branch_count = 32'h0; branch_mispredicts = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(rd_valid), 32'h0);
        check("reset_data", rd_data, 32'h0);
        check("reset_err", 32'(rd_err), 32'h0);
        reset = 1'b0;

        // Plain lo read, one-cycle valid pulse
        cyc64 = 64'h123;
        step(1'b1, 12'hC00);
        step(1'b0, 12'h0);
        step(1'b1, 12'hC80);  // consume the shadow armed by the lo read
        step(1'b0, 12'h0);

        // Hi read in the wrap cycle sees the post-wrap value, twice over
        cyc64 = 64'h0_FFFF_FFFF;
        step(1'b0, 12'h0);
        cyc64 = cyc64 + 1;
        step(1'b1, 12'hC80);
        cyc64 = 64'h1_FFFF_FFFF;
        step(1'b0, 12'h0);
        cyc64 = cyc64 + 1;
        step(1'b1, 12'hC80);
        step(1'b0, 12'h0);
        check("cycleh_after_two_wraps", exp_data, 32'h2);

        // Instret hi to 5, then snapshot across a wrap
        repeat (5) begin
            ins64 = {ins64[63:32], 32'hFFFF_FFFF};
            step(1'b0, 12'h0);
            ins64 = ins64 + 1;
            step(1'b0, 12'h0);
        end
        ins64 = {ins64[63:32], 32'hFFFF_FFFF};
        step(1'b1, 12'hC02);
        ins64 = ins64 + 1;
        step(1'b1, 12'hC82);
        step(1'b1, 12'hC82);
        step(1'b0, 12'h0);

        // Event counters back to back
        stall_v = 32'd7; br_v = 32'd9; mis_v = 32'd2;
        step(1'b1, 12'hC03);
        step(1'b1, 12'hC04);
        step(1'b1, 12'hC05);
        step(1'b0, 12'h0);

        // Illegal and zero-reading addresses
        step(1'b1, 12'h300);
        step(1'b1, 12'hC84);
        step(1'b0, 12'h0);

        // Randomized traffic with wraps on both 64-bit counters
        cyc64 = {cyc64[63:32], 32'hFFFF_FF00};
        ins64 = {ins64[63:32], 32'hFFFF_FF80};
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 1) cyc64 = cyc64 + 1;
            if ($urandom_range(0, 1) == 1) ins64 = ins64 + 1;
            stall_v = $urandom;
            br_v    = $urandom;
            mis_v   = $urandom;
            req     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) a = 12'($urandom);
            else a = addr_tab[$urandom_range(0, 11)];
            step(req, a);
        end

        // Reset lands while a response is being presented
        cyc64 = {cyc64[63:32], cyc64[31:0] + 32'h1};
        step(1'b1, 12'hC00);
        @(posedge clk);
        #2;
        reset  = 1'b1;
        rd_req = 1'b0;
        #1;
        check("async_reset_valid", 32'(rd_valid), 32'h0);
        check("async_reset_data", rd_data, 32'h0);
        cyc64 = {32'h0, cyc64[31:0]};
        ins64 = {32'h0, ins64[31:0]};
        sh_vld_c = 1'b0; sh_vld_i = 1'b0;
        exp_valid = 1'b0; exp_data = 32'h0; exp_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 12'hC80);
        step(1'b0, 12'h0);
        check("cycleh_after_reset", exp_data, 32'h0);
        step(1'b0, 12'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
